// File: rtl/gate_bist_if.sv
// rtl/gate_bist_if.sv - control and gate-drive bundle between a BIST host and gate_bist
//
// Signals:
//   start          host -> bist  begin a sweep (honoured only while idle)
//   gate_out       gut  -> bist  output of the gate under test
//   gate_a/gate_b  bist -> gut   stimulus, gate_a is vector bit 1, gate_b bit 0
//   busy           bist -> host  sweep in progress
//   done           bist -> host  one-cycle end-of-sweep pulse
//   pass           bist -> host  all four vectors matched
//   fail_map[3:0]  bist -> host  bit i set = vector i mismatched
//   first_fail_vec/first_fail_vld  present only with GATE_BIST_ERRLOG_EN
// Modports: slave = the BIST engine, master = the host/GUT side.
interface gate_bist_if;
  logic       start;
  logic       gate_out;
  logic       gate_a;
  logic       gate_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_map;
`ifdef GATE_BIST_ERRLOG_EN
  logic [1:0] first_fail_vec;
  logic       first_fail_vld;

  modport slave (
    input  start, gate_out,
    output gate_a, gate_b, busy, done, pass, fail_map, first_fail_vec, first_fail_vld
  );
  modport master (
    output start, gate_out,
    input  gate_a, gate_b, busy, done, pass, fail_map, first_fail_vec, first_fail_vld
  );
`else
  modport slave (
    input  start, gate_out,
    output gate_a, gate_b, busy, done, pass, fail_map
  );
  modport master (
    output start, gate_out,
    input  gate_a, gate_b, busy, done, pass, fail_map
  );
`endif
endinterface

// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - self-test engine sweeping the four input vectors of a 2-input gate
//
// Drives {gate_a,gate_b} = 00,01,10,11 in turn, holds each SETTLE_CYCLES+1 cycles,
// samples gate_out on the last of those cycles and compares against EXPECTED[vec].
// Optional first-failure log enabled by defining GATE_BIST_ERRLOG_EN.
//
// Parameters:
//   EXPECTED       truth table, bit i = expected gate_out for vector i ({a,b})
//   SETTLE_CYCLES  settle cycles before sampling, legal 1..255
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   bus            gate_bist_if.slave: start/gate_out in; gate_a, gate_b, busy, done,
//                  pass, fail_map (and first_fail_vec/vld) out
module gate_bist #(
  parameter logic [3:0]  EXPECTED      = 4'b0111,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  gate_bist_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_vec, w_vec_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_fail_map, w_fail_map_nxt;
  logic       r_pass, w_pass_nxt;
  logic       w_mismatch;
  logic       w_drive;
`ifdef GATE_BIST_ERRLOG_EN
  logic [1:0] r_ff_vec, w_ff_vec_nxt;
  logic       r_ff_vld, w_ff_vld_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_vec      <= 2'd0;
      r_cnt      <= 8'd0;
      r_fail_map <= 4'd0;
      r_pass     <= 1'b0;
`ifdef GATE_BIST_ERRLOG_EN
      r_ff_vec   <= 2'd0;
      r_ff_vld   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_vec      <= w_vec_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fail_map <= w_fail_map_nxt;
      r_pass     <= w_pass_nxt;
`ifdef GATE_BIST_ERRLOG_EN
      r_ff_vec   <= w_ff_vec_nxt;
      r_ff_vld   <= w_ff_vld_nxt;
`endif
    end
  end

  assign w_mismatch = (bus.gate_out != EXPECTED[r_vec]);

  always_comb begin
    w_state_nxt    = r_state;
    w_vec_nxt      = r_vec;
    w_cnt_nxt      = r_cnt;
    w_fail_map_nxt = r_fail_map;
    w_pass_nxt     = r_pass;
`ifdef GATE_BIST_ERRLOG_EN
    w_ff_vec_nxt   = r_ff_vec;
    w_ff_vld_nxt   = r_ff_vld;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt    = S_SETTLE;
          w_vec_nxt      = 2'd0;
          w_cnt_nxt      = 8'd0;
          w_fail_map_nxt = 4'd0;
          w_pass_nxt     = 1'b0;
`ifdef GATE_BIST_ERRLOG_EN
          w_ff_vec_nxt   = 2'd0;
          w_ff_vld_nxt   = 1'b0;
`endif
        end
      end
      S_SETTLE: begin
        w_cnt_nxt = r_cnt + 8'd1;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        w_fail_map_nxt = r_fail_map | (4'(w_mismatch) << r_vec);
`ifdef GATE_BIST_ERRLOG_EN
        // Only the first mismatch of a sweep is logged.
        if (w_mismatch && !r_ff_vld) begin
          w_ff_vec_nxt = r_vec;
          w_ff_vld_nxt = 1'b1;
        end
`endif
        if (r_vec != 2'd3) begin
          w_vec_nxt   = r_vec + 2'd1;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_SETTLE;
        end else begin
          // Verdict registered on entry to DONE so it is valid with the done pulse
          // and already includes this final sample.
          w_pass_nxt  = (w_fail_map_nxt == 4'd0);
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The vector is presented during both settle and sample; gate inputs rest at 0 otherwise.
  assign w_drive      = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign bus.gate_a   = w_drive & r_vec[1];
  assign bus.gate_b   = w_drive & r_vec[0];
  assign bus.busy     = w_drive;
  assign bus.done     = (r_state == S_DONE);
  assign bus.pass     = r_pass;
  assign bus.fail_map = r_fail_map;
`ifdef GATE_BIST_ERRLOG_EN
  assign bus.first_fail_vec = r_ff_vec;
  assign bus.first_fail_vld = r_ff_vld;
`endif

endmodule

// File: tb/tb_gate_bist.sv
// tb/tb_gate_bist.sv - directed bench for gate_bist with a modelled gate under test
module tb_gate_bist;

  logic clk;
  logic rst_n;
  int   gut_mode;
  int   total;
  int   bad;

  gate_bist_if bus();
  gate_bist_if bus_b();

  gate_bist #(.EXPECTED(4'b0111), .SETTLE_CYCLES(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  gate_bist #(.EXPECTED(4'b1000), .SETTLE_CYCLES(2)) u_dut_and (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gut_mode: 0 NAND, 1 stuck-at-1, 2 stuck-at-0, 3 AND
  always_comb begin
    case (gut_mode)
      1:       bus.gate_out = 1'b1;
      2:       bus.gate_out = 1'b0;
      3:       bus.gate_out = bus.gate_a & bus.gate_b;
      default: bus.gate_out = ~(bus.gate_a & bus.gate_b);
    endcase
  end

  assign bus_b.gate_out = bus_b.gate_a & bus_b.gate_b;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sweep on the NAND-table instance; cycle c is the c-th cycle after the accepting edge.
  task automatic run_sweep(input int mode_i, input int repulse, input logic [3:0] exp_map,
                           input logic [1:0] exp_first, input string nm);
    logic [1:0] ev;
    gut_mode = mode_i;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == repulse) bus.start = 1'b1;
      if (c == repulse + 1) bus.start = 1'b0;
      if (c <= 12) begin
        ev = 2'((c - 1) / 3);
        check($sformatf("%s vec c%0d", nm, c), {6'd0, bus.gate_a, bus.gate_b}, {6'd0, ev});
        check($sformatf("%s busy c%0d", nm, c), {7'd0, bus.busy}, 8'd1);
        check($sformatf("%s done c%0d", nm, c), {7'd0, bus.done}, 8'd0);
      end else if (c == 13) begin
        check($sformatf("%s gates at done", nm), {6'd0, bus.gate_a, bus.gate_b}, 8'd0);
        check($sformatf("%s busy at done", nm), {7'd0, bus.busy}, 8'd0);
        check($sformatf("%s done c13", nm), {7'd0, bus.done}, 8'd1);
        check($sformatf("%s pass", nm), {7'd0, bus.pass}, {7'd0, (exp_map == 4'd0)});
        check($sformatf("%s fail_map", nm), {4'd0, bus.fail_map}, {4'd0, exp_map});
`ifdef GATE_BIST_ERRLOG_EN
        check($sformatf("%s ff_vld", nm), {7'd0, bus.first_fail_vld}, {7'd0, (exp_map != 4'd0)});
        if (exp_map != 4'd0)
          check($sformatf("%s ff_vec", nm), {6'd0, bus.first_fail_vec}, {6'd0, exp_first});
`endif
      end else begin
        check($sformatf("%s done after", nm), {7'd0, bus.done}, 8'd0);
        check($sformatf("%s busy after", nm), {7'd0, bus.busy}, 8'd0);
        check($sformatf("%s pass held", nm), {7'd0, bus.pass}, {7'd0, (exp_map == 4'd0)});
        check($sformatf("%s map held", nm), {4'd0, bus.fail_map}, {4'd0, exp_map});
      end
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    gut_mode    = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus_b.start = 1'b0;

    #1;
    check("rst busy", {7'd0, bus.busy}, 8'd0);
    check("rst done", {7'd0, bus.done}, 8'd0);
    check("rst pass", {7'd0, bus.pass}, 8'd0);
    check("rst map", {4'd0, bus.fail_map}, 8'd0);
    check("rst gates", {6'd0, bus.gate_a, bus.gate_b}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_sweep(0, 0, 4'b0000, 2'd0, "nand");
    run_sweep(1, 0, 4'b1000, 2'd3, "stuck1");
    run_sweep(2, 0, 4'b0111, 2'd0, "stuck0");
    run_sweep(3, 0, 4'b1111, 2'd0, "and_vs_nand");

    // AND table instance with start held high across the end of a sweep.
    @(negedge clk);
    bus_b.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      if (c == 15) bus_b.start = 1'b0;
      if (c == 13) begin
        check("andtab done", {7'd0, bus_b.done}, 8'd1);
        check("andtab pass", {7'd0, bus_b.pass}, 8'd1);
        check("andtab map", {4'd0, bus_b.fail_map}, 8'd0);
      end
      if (c == 14) begin
        check("andtab idle busy", {7'd0, bus_b.busy}, 8'd0);
        check("andtab idle pass", {7'd0, bus_b.pass}, 8'd1);
      end
      if (c == 15) begin
        check("andtab rerun busy", {7'd0, bus_b.busy}, 8'd1);
        check("andtab rerun pass clr", {7'd0, bus_b.pass}, 8'd0);
      end
      if (c == 26) check("andtab rerun pre", {7'd0, bus_b.done}, 8'd0);
      if (c == 27) begin
        check("andtab rerun done", {7'd0, bus_b.done}, 8'd1);
        check("andtab rerun pass", {7'd0, bus_b.pass}, 8'd1);
      end
    end
    repeat (2) @(negedge clk);

    run_sweep(0, 5, 4'b0000, 2'd0, "repulse");

    // Reset mid-sweep at cycle 7.
    gut_mode = 2;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    check("pre-reset busy", {7'd0, bus.busy}, 8'd1);
    check("pre-reset map", {4'd0, bus.fail_map}, 8'h03);
    rst_n = 1'b0;
    #1;
    check("abort busy", {7'd0, bus.busy}, 8'd0);
    check("abort done", {7'd0, bus.done}, 8'd0);
    check("abort map", {4'd0, bus.fail_map}, 8'd0);
    check("abort pass", {7'd0, bus.pass}, 8'd0);
    check("abort gates", {6'd0, bus.gate_a, bus.gate_b}, 8'd0);
`ifdef GATE_BIST_ERRLOG_EN
    check("abort ff_vld", {7'd0, bus.first_fail_vld}, 8'd0);
    check("abort ff_vec", {6'd0, bus.first_fail_vec}, 8'd0);
`endif
    @(negedge clk);
    check("in-reset done", {7'd0, bus.done}, 8'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check($sformatf("post-reset idle done c%0d", c), {7'd0, bus.done}, 8'd0);
      check($sformatf("post-reset idle busy c%0d", c), {7'd0, bus.busy}, 8'd0);
    end
    run_sweep(0, 0, 4'b0000, 2'd0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
